vend_sequencer: RTL and testbench

- Initiator side of the vending-machine purchase interface (start / product / coin5 / coin10 in; issue_prod / not_available / change5 back).
- Accepts one purchase request (product code plus counts of 10- and 5-unit coins) and drives the machine through the start, product-select and coin-insertion sequence.
- Watches for the machine's vend or not-available result, then returns a single response record.
- Used as the customer-side driver in system builds and as a reusable stimulus engine for machine verification.

---
 rtl/vend_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_vend_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/vend_sequencer.sv
// vend_sequencer: customer-side driver for the vending machine purchase
// interface. It takes one purchase request, runs the start / product-select /
// coin sequence, watches for the machine's result and returns one response.
module vend_sequencer #(
  parameter int START_CYCLES = 2,
  parameter int COIN_GAP     = 1,
  parameter int TIMEOUT      = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_product,
  input  logic [2:0] req_n10,
  input  logic [2:0] req_n5,
  output logic       start,
  output logic [1:0] product,
  output logic       coin5,
  output logic       coin10,
  input  logic       issue_prod,
  input  logic       not_available,
  input  logic [1:0] change5,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [1:0] rsp_status,
  output logic [1:0] rsp_change,
  output logic [6:0] rsp_paid
);

  // One counter is shared by the START, GAP and WAIT phases, so size it for
  // the longest of the three.
  localparam int CMAX0 = (START_CYCLES > COIN_GAP) ? START_CYCLES : COIN_GAP;
  localparam int CMAX  = (CMAX0 > TIMEOUT) ? CMAX0 : TIMEOUT;
  localparam int CW    = (CMAX < 2) ? 1 : $clog2(CMAX + 1);

  localparam logic [1:0] ST_OK = 2'b00;
  localparam logic [1:0] ST_NA = 2'b01;
  localparam logic [1:0] ST_TO = 2'b10;

  typedef enum logic [2:0] {
    IDLE, START, COIN, GAP, WAIT, RESP
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    n10_q, n5_q;
  logic [1:0]    prod_q;
  logic          start_q, coin5_q, coin10_q;
  logic          rsp_valid_q;
  logic [1:0]    status_q, change_q;
  logic [6:0]    paid_q;

  logic          active;
  logic          hit;
  logic [2:0]    rem10_d, rem5_d;
  logic [6:0]    paid_d;

  // Result detection window, coins left after the pulse now on the bus, and
  // the paid total including that pulse.
  always_comb begin
    active  = (state_q == START) || (state_q == COIN) ||
              (state_q == GAP)   || (state_q == WAIT);
    hit     = active && (issue_prod || not_available);
    rem10_d = n10_q - {2'b00, coin10_q};
    rem5_d  = n5_q  - {2'b00, coin5_q};
    paid_d  = paid_q;
    if (coin10_q)     paid_d = paid_q + 7'd10;
    else if (coin5_q) paid_d = paid_q + 7'd5;
  end

  // Sequencer FSM with all interface outputs registered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      n10_q       <= '0;
      n5_q        <= '0;
      prod_q      <= '0;
      start_q     <= 1'b0;
      coin5_q     <= 1'b0;
      coin10_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      status_q    <= '0;
      change_q    <= '0;
      paid_q      <= '0;
    end else if (hit) begin
      // A result ends the sequence; a coin already on the bus still counts.
      state_q     <= RESP;
      cnt_q       <= '0;
      start_q     <= 1'b0;
      coin5_q     <= 1'b0;
      coin10_q    <= 1'b0;
      rsp_valid_q <= 1'b1;
      paid_q      <= paid_d;
      if (not_available) begin
        status_q <= ST_NA;
        change_q <= 2'b00;
      end else begin
        status_q <= ST_OK;
        change_q <= change5;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            state_q  <= START;
            cnt_q    <= '0;
            prod_q   <= req_product;
            n10_q    <= req_n10;
            n5_q     <= req_n5;
            paid_q   <= '0;
            status_q <= '0;
            change_q <= '0;
            start_q  <= 1'b1;
          end
        end
        START: begin
          if (cnt_q == CW'(START_CYCLES - 1)) begin
            start_q <= 1'b0;
            cnt_q   <= '0;
            if ((n10_q != 3'd0) || (n5_q != 3'd0)) begin
              state_q  <= COIN;
              coin10_q <= (n10_q != 3'd0);
              coin5_q  <= (n10_q == 3'd0);
            end else begin
              state_q <= WAIT;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        COIN: begin
          paid_q   <= paid_d;
          n10_q    <= rem10_d;
          n5_q     <= rem5_d;
          cnt_q    <= '0;
          coin5_q  <= 1'b0;
          coin10_q <= 1'b0;
          if ((rem10_d != 3'd0) || (rem5_d != 3'd0)) begin
            if (COIN_GAP > 0) begin
              state_q <= GAP;
            end else begin
              state_q  <= COIN;
              coin10_q <= (rem10_d != 3'd0);
              coin5_q  <= (rem10_d == 3'd0);
            end
          end else begin
            state_q <= WAIT;
          end
        end
        GAP: begin
          if (cnt_q == CW'(COIN_GAP - 1)) begin
            state_q  <= COIN;
            cnt_q    <= '0;
            coin10_q <= (n10_q != 3'd0);
            coin5_q  <= (n10_q == 3'd0);
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WAIT: begin
          if (cnt_q == CW'(TIMEOUT - 1)) begin
            state_q     <= RESP;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b1;
            status_q    <= ST_TO;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            prod_q      <= '0;
            paid_q      <= '0;
            status_q    <= '0;
            change_q    <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign start      = start_q;
  assign product    = prod_q;
  assign coin5      = coin5_q;
  assign coin10     = coin10_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_status = status_q;
  assign rsp_change = change_q;
  assign rsp_paid   = paid_q;

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed bench for vend_sequencer with a small behavioural machine model.
module tb_vend_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_product;
  logic [2:0] req_n10, req_n5;
  logic       start;
  logic [1:0] product;
  logic       coin5, coin10;
  logic       issue_prod, not_available;
  logic [1:0] change5;
  logic       rsp_valid, rsp_ready;
  logic [1:0] rsp_status, rsp_change;
  logic [6:0] rsp_paid;

  int checks = 0;
  int failures = 0;

  // machine model configuration and observation counters
  int mode = 0;     // 0 silent, 1 issue on Nth coin, 2 issue cycle after Nth coin, 3 NA+issue on start
  int target = 0;
  int chg = 0;
  logic pend = 1'b0;
  logic coin_now;
  int ncoin = 0, n_c5 = 0, n_c10 = 0, n_start = 0, n_both = 0;
  int since = 0, last_gap = -1;

  vend_sequencer dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_product(req_product),
    .req_n10(req_n10), .req_n5(req_n5),
    .start(start), .product(product), .coin5(coin5), .coin10(coin10),
    .issue_prod(issue_prod), .not_available(not_available), .change5(change5),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_status(rsp_status), .rsp_change(rsp_change), .rsp_paid(rsp_paid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Observe outputs mid-cycle and answer like the machine would.
  always @(negedge clk) begin
    coin_now = coin5 | coin10;
    if (coin5 && coin10) n_both++;
    if (start) n_start++;
    if (coin5) n_c5++;
    if (coin10) n_c10++;
    if (coin_now) begin
      if (ncoin > 0) last_gap = since;
      since = 0;
      ncoin++;
    end else if (!rsp_valid) begin
      since++;
    end
    issue_prod = 1'b0;
    not_available = 1'b0;
    change5 = 2'd0;
    case (mode)
      1: if (coin_now && ncoin == target) begin issue_prod = 1'b1; change5 = 2'(chg); end
      2: begin
        if (pend) begin issue_prod = 1'b1; change5 = 2'(chg); end
        pend = coin_now && (ncoin == target);
      end
      3: if (start) begin not_available = 1'b1; issue_prod = 1'b1; change5 = 2'd3; end
      default: ;
    endcase
  end

  task automatic clr_obs();
    ncoin = 0; n_c5 = 0; n_c10 = 0; n_start = 0; n_both = 0;
    since = 0; last_gap = -1; pend = 1'b0;
  endtask

  // Issue one request and wait (bounded) for the response.
  task automatic do_txn(input int prod, input int n10, input int n5);
    int k;
    @(negedge clk);
    clr_obs();
    req_product = 2'(prod); req_n10 = 3'(n10); req_n5 = 3'(n5);
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("req_ready_busy", int'(req_ready), 0);
    k = 0;
    while (!rsp_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("rsp_arrived", int'(rsp_valid), 1);
  endtask

  // Check the response, hold it for a while, then complete the handshake.
  task automatic end_rsp(input int hold, input int st, input int ch, input int pd, input int prod);
    chk("rsp_status", int'(rsp_status), st);
    chk("rsp_change", int'(rsp_change), ch);
    chk("rsp_paid", int'(rsp_paid), pd);
    chk("product_resp", int'(product), prod);
    chk("coin_overlap", n_both, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", int'(rsp_valid), 1);
      chk("hold_ready", int'(req_ready), 0);
      chk("hold_status", int'(rsp_status), st);
      chk("hold_paid", int'(rsp_paid), pd);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_drop", int'(rsp_valid), 0);
    chk("ready_back", int'(req_ready), 1);
  endtask

  initial begin
    int k;
    int seen;
    reset = 1'b0; req_valid = 1'b0; req_product = '0; req_n10 = '0; req_n5 = '0;
    rsp_ready = 1'b0; issue_prod = 1'b0; not_available = 1'b0; change5 = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_start", int'(start), 0);
    chk("rst_coin5", int'(coin5), 0);
    chk("rst_coin10", int'(coin10), 0);
    chk("rst_product", int'(product), 0);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_status", int'(rsp_status), 0);
    chk("rst_change", int'(rsp_change), 0);
    chk("rst_paid", int'(rsp_paid), 0);
    chk("rst_req_ready", int'(req_ready), 1);

    // single 5 coin, vend the cycle after the coin
    mode = 2; target = 1; chg = 0;
    do_txn(0, 0, 1);
    chk("t1_start_cyc", n_start, 2);
    chk("t1_c5", n_c5, 1);
    chk("t1_c10", n_c10, 0);
    end_rsp(0, 0, 0, 5, 0);

    // two 10 coins, vend on the second one; the 5 coin is never inserted
    mode = 1; target = 2; chg = 0;
    do_txn(3, 2, 1);
    chk("t2_c10", n_c10, 2);
    chk("t2_c5", n_c5, 0);
    chk("t2_gap", last_gap, 1);
    end_rsp(0, 0, 0, 20, 3);

    // vend with one coin of change
    mode = 2; target = 1; chg = 1;
    do_txn(1, 1, 0);
    chk("t3_c10", n_c10, 1);
    end_rsp(0, 0, 1, 10, 1);

    // not_available together with issue_prod during START
    mode = 3;
    do_txn(2, 3, 0);
    chk("t4_start_cyc", n_start, 1);
    chk("t4_c10", n_c10, 0);
    end_rsp(0, 1, 0, 0, 2);

    // silent machine: timeout after exactly 15 wait cycles, response held
    mode = 0;
    do_txn(0, 0, 2);
    chk("t5_c5", n_c5, 2);
    chk("t5_gap", last_gap, 1);
    chk("t5_wait", since, 15);
    end_rsp(5, 2, 0, 10, 0);

    // reset during the second coin pulse
    mode = 0;
    @(negedge clk);
    clr_obs();
    req_product = 2'd1; req_n10 = 3'd3; req_n5 = 3'd0;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    k = 0;
    for (int i = 0; i < 100 && k < 2; i++) begin
      if (coin10) k++;
      if (k < 2) @(negedge clk);
    end
    chk("t6_reach_coin2", k, 2);
    reset = 1'b0;
    @(negedge clk);
    chk("t6_start", int'(start), 0);
    chk("t6_coin10", int'(coin10), 0);
    chk("t6_coin5", int'(coin5), 0);
    chk("t6_rsp_valid", int'(rsp_valid), 0);
    chk("t6_product", int'(product), 0);
    chk("t6_paid", int'(rsp_paid), 0);
    chk("t6_idle", int'(req_ready), 1);
    reset = 1'b1;
    n_c10 = 0; n_c5 = 0; seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("t6_no_coins", n_c10 + n_c5, 0);
    chk("t6_no_rsp", seen, 0);

    // normal transaction after reset
    mode = 2; target = 1; chg = 1;
    do_txn(1, 1, 0);
    chk("t7_c10", n_c10, 1);
    end_rsp(0, 0, 1, 10, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
